// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction fetch responder (req/gnt/rvalid) with preloadable word array

module instr_mem_responder #(
  parameter int RDATA_WIDTH     = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int GNT_WAIT        = 0,
  parameter int RVALID_LAT      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               instr_req_i,
  input  logic [31:0]                        instr_addr_i,
  output logic                               instr_gnt_o,
  output logic                               instr_rvalid_o,
  output logic [RDATA_WIDTH-1:0]             instr_rdata_o,
  input  logic                               wr_en_i,
  input  logic [$clog2(MEM_WORDS)-1:0]       wr_addr_i,
  input  logic [RDATA_WIDTH-1:0]             wr_data_i,
  output logic                               oob_err_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);

  localparam int BYTES    = RDATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_BITS = $clog2(MEM_WORDS);
  localparam int HI_LSB   = OFF_BITS + IDX_BITS;
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int CNT_W    = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   wait_done;
  logic                   room;
  logic [IDX_BITS-1:0]    rd_idx;
  logic                   addr_oob;
  logic [RDATA_WIDTH-1:0] rd_word;
  logic [RDATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                   vld_pipe [RVALID_LAT];
  logic [RDATA_WIDTH-1:0] dat_pipe [RVALID_LAT];

  // Address decode: byte offset bits are dropped, anything above the index is out of range.
  assign rd_idx   = instr_addr_i[OFF_BITS +: IDX_BITS];
  assign addr_oob = ((instr_addr_i >> HI_LSB) != 32'd0);
  assign rd_word  = addr_oob ? '0 : mem[rd_idx];

  // Preload/patch port; the array is intentionally not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // A slot is free if below the limit, or if the oldest read retires this very cycle.
  assign room = (outstanding_o < OUT_W'(MAX_OUTSTANDING)) ||
                ((outstanding_o == OUT_W'(MAX_OUTSTANDING)) && instr_rvalid_o);

  assign wait_done = (GNT_WAIT == 0) ||
                     ((state == WAIT_GNT) && (cnt == CNT_W'(GNT_WAIT)));

  // Grant FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant FSM next state and combinational gnt; every request pays the full wait.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    instr_gnt_o = instr_req_i && wait_done && room;
    case (state)
      IDLE: begin
        if (instr_req_i && (GNT_WAIT > 0)) begin
          state_nxt = WAIT_GNT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT_GNT: begin
        if (!instr_req_i || instr_gnt_o) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != CNT_W'(GNT_WAIT)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outstanding read count: +1 per grant, -1 per returned word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o <= '0;
    end else begin
      case ({instr_gnt_o, instr_rvalid_o})
        2'b10:   outstanding_o <= outstanding_o + OUT_W'(1);
        2'b01:   outstanding_o <= outstanding_o - OUT_W'(1);
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

  // Sticky out-of-range flag, raised only by a granted access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_err_o <= 1'b0;
    end else if (instr_gnt_o && addr_oob) begin
      oob_err_o <= 1'b1;
    end
  end

  // First latency stage: capture the word read in the grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[0] <= 1'b0;
      dat_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= instr_gnt_o;
      if (instr_gnt_o) begin
        dat_pipe[0] <= rd_word;
      end
    end
  end

  for (genvar s = 1; s < RVALID_LAT; s++) begin : g_stage
    // Later stages: data moves only behind a valid word so the output holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe[s] <= 1'b0;
        dat_pipe[s] <= '0;
      end else begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
        end
      end
    end
  end

  assign instr_rvalid_o = vld_pipe[RVALID_LAT-1];
  assign instr_rdata_o  = dat_pipe[RVALID_LAT-1];

  a_cfg: assert property (@(posedge clk)
    (RVALID_LAT >= 1) && (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= RVALID_LAT));

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_o |-> (outstanding_o != '0));

  a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
    outstanding_o <= OUT_W'(MAX_OUTSTANDING));

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)));

endmodule
